// File: rtl/alu_sequencer.sv
// Command-driven front end for a combinational ALU: holds the A/B/F operand registers and issues EXEC commands.
// It captures the ALU result and flags, then returns them over a valid/ready response stream.
module alu_sequencer #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_kind,
    input  logic [3:0]   cmd_ctrl,
    input  logic         cmd_wb,
    input  logic [n-1:0] cmd_data,
    output logic [n-1:0] ALUA,
    output logic [n-1:0] ALUB,
    output logic         ALUFlagIn,
    output logic [3:0]   ALUControl,
    input  logic [n-1:0] ALUResult,
    input  logic [1:0]   ALUFlags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_result,
    output logic [1:0]   rsp_flags,
    output logic         busy,
    output logic [7:0]   exec_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [1:0] K_LOAD_A = 2'b00;
    localparam logic [1:0] K_LOAD_B = 2'b01;
    localparam logic [1:0] K_EXEC   = 2'b10;
    localparam logic [1:0] K_SETF   = 2'b11;

    state_t       state, state_nxt;
    logic [n-1:0] a_q, b_q;
    logic         f_q;
    logic [3:0]   ctrl_q;
    logic         wb_q;
    logic         cmd_fire, rsp_fire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire && cmd_kind == K_EXEC) state_nxt = DRIVE;
            DRIVE:   state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state, so reset drops rsp_valid asynchronously.
    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= 1'b0;
            ctrl_q     <= '0;
            wb_q       <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            exec_count <= '0;
        end else begin
            if (cmd_fire) begin
                case (cmd_kind)
                    K_LOAD_A: a_q <= cmd_data;
                    K_LOAD_B: b_q <= cmd_data;
                    K_SETF:   f_q <= cmd_data[0];
                    K_EXEC: begin
                        ctrl_q <= cmd_ctrl;
                        wb_q   <= cmd_wb;
                    end
                    default: ;
                endcase
            end
            // ALU inputs have been stable for the whole DRIVE cycle; sample its outputs now.
            if (state == DRIVE) begin
                rsp_result <= ALUResult;
                rsp_flags  <= ALUFlags;
                f_q        <= ALUFlags[0];
                if (wb_q) a_q <= ALUResult;
            end
            if (rsp_fire) exec_count <= exec_count + 8'd1;
        end
    end

    assign ALUA       = a_q;
    assign ALUB       = b_q;
    assign ALUFlagIn  = f_q;
    assign ALUControl = ctrl_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized bench for alu_sequencer with a stand-in ALU and a transaction-level model.
// The model tracks A/B/F/count; every expectation is derived from the command rules.
module tb_alu_sequencer;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_kind = '0;
    logic [3:0]   cmd_ctrl = '0;
    logic         cmd_wb = 1'b0;
    logic [N-1:0] cmd_data = '0;
    logic [N-1:0] ALUA, ALUB;
    logic         ALUFlagIn;
    logic [3:0]   ALUControl;
    logic [N-1:0] ALUResult;
    logic [1:0]   ALUFlags;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic [1:0]   rsp_flags;
    logic         busy;
    logic [7:0]   exec_count;

    int checks = 0;
    int failures = 0;

    logic [N-1:0] ma, mb;
    logic         mf;
    logic [7:0]   mcnt;

    alu_sequencer #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_ctrl(cmd_ctrl), .cmd_wb(cmd_wb), .cmd_data(cmd_data),
        .ALUA(ALUA), .ALUB(ALUB), .ALUFlagIn(ALUFlagIn), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .busy(busy), .exec_count(exec_count)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: {zero, carry, result}. Codes 8/9 rotate through the carry flag.
    function automatic logic [N+1:0] alu_ref(input logic [3:0] c, input logic [N-1:0] a,
                                             input logic [N-1:0] b, input logic fi);
        logic [N-1:0] r;
        logic         co;
        r  = '0;
        co = 1'b0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h3: r = a - b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: r = a << 1;
            4'h7: r = a >> 1;
            4'h8: begin r = {a[N-2:0], fi}; co = a[N-1]; end
            4'h9: begin r = {fi, a[N-1:1]}; co = a[0];   end
            default: r = '0;
        endcase
        return {(r == '0), co, r};
    endfunction

    always_comb {ALUFlags, ALUResult} = alu_ref(ALUControl, ALUA, ALUB, ALUFlagIn);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ma = '0; mb = '0; mf = 1'b0; mcnt = '0;
    endtask

    // Non-EXEC command; starts and ends away from the rising edge.
    task automatic do_load(input logic [1:0] k, input logic [N-1:0] d);
        cmd_kind = k; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        case (k)
            2'b00: ma = d;
            2'b01: mb = d;
            2'b11: mf = d[0];
            default: ;
        endcase
        @(negedge clk);
        chk("load_A", 32'(ALUA), 32'(ma));
        chk("load_B", 32'(ALUB), 32'(mb));
        chk("load_F", 32'(ALUFlagIn), 32'(mf));
        chk("load_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_exec(input logic [3:0] c, input logic wb, input int hold);
        logic [N+1:0] e;
        chk("exec_ready", 32'(cmd_ready), 32'd1);
        cmd_kind = 2'b10; cmd_ctrl = c; cmd_wb = wb; cmd_data = N'($urandom);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("drive_busy", 32'(busy), 32'd1);
        chk("drive_novalid", 32'(rsp_valid), 32'd0);
        chk("drive_ctrl", 32'(ALUControl), 32'(c));
        chk("drive_flagin", 32'(ALUFlagIn), 32'(mf));
        chk("drive_cmdready", 32'(cmd_ready), 32'd0);
        e = alu_ref(c, ma, mb, mf);
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_result", 32'(rsp_result), 32'(e[N-1:0]));
        chk("rsp_flags", 32'(rsp_flags), 32'(e[N+1:N]));
        mf = e[N];
        if (wb) ma = e[N-1:0];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result", 32'(rsp_result), 32'(e[N-1:0]));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        mcnt = mcnt + 8'd1;
        @(negedge clk);
        chk("post_count", 32'(exec_count), 32'(mcnt));
        chk("post_ready", 32'(cmd_ready), 32'd1);
        chk("post_A", 32'(ALUA), 32'(ma));
        chk("post_F", 32'(ALUFlagIn), 32'(mf));
    endtask

    initial begin
        logic [N+1:0] e;
        int execs;
        model_reset();
        #2;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_A", 32'(ALUA), 32'd0);
        chk("rst_ctrl", 32'(ALUControl), 32'd0);
        chk("rst_count", 32'(exec_count), 32'd0);
        #10 rst_n = 1'b1;

        // Add: 0101 + 0011 = 1000
        do_load(2'b00, 4'b0101);
        do_load(2'b01, 4'b0011);
        do_load(2'b11, 4'b0000);
        do_exec(4'h2, 1'b0, 0);
        chk("add_result", 32'(rsp_result), 32'b1000);
        chk("add_count", 32'(exec_count), 32'd1);

        // Shift with carry-in
        do_load(2'b00, 4'b0011);
        do_load(2'b01, 4'b0001);
        do_load(2'b11, 4'b0001);
        do_exec(4'h8, 1'b0, 1);
        chk("shl_result", 32'(rsp_result), 32'b0111);
        chk("shl_F", 32'(ALUFlagIn), 32'd0);

        // Write-back chain
        do_load(2'b00, 4'b1111);
        do_load(2'b01, 4'b1111);
        do_load(2'b11, 4'b0000);
        do_exec(4'h3, 1'b1, 0);
        chk("wb_flags", 32'(rsp_flags), 32'b10);
        chk("wb_A", 32'(ALUA), 32'd0);
        do_load(2'b01, 4'b0000);
        do_exec(4'h1, 1'b0, 0);
        chk("chain_result", 32'(rsp_result), 32'd0);
        chk("chain_flags", 32'(rsp_flags), 32'b10);

        // Backpressure with a pending LOAD_A
        do_load(2'b00, 4'b0110);
        do_load(2'b01, 4'b0011);
        cmd_kind = 2'b10; cmd_ctrl = 4'h4; cmd_wb = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_kind = 2'b00; cmd_data = 4'b1010;
        e = alu_ref(4'h4, ma, mb, mf);
        mf = e[N];
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", 32'(rsp_result), 32'(e[N-1:0]));
            chk("bp_flags", 32'(rsp_flags), 32'(e[N+1:N]));
            chk("bp_ready", 32'(cmd_ready), 32'd0);
            chk("bp_A", 32'(ALUA), 32'(ma));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        mcnt = mcnt + 8'd1;
        @(negedge clk);
        chk("bp_post_ready", 32'(cmd_ready), 32'd1);
        chk("bp_post_A", 32'(ALUA), 32'(ma));
        chk("bp_count", 32'(exec_count), 32'(mcnt));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ma = 4'b1010;
        @(negedge clk);
        chk("bp_load_A", 32'(ALUA), 32'b1010);

        // Reset during DRIVE
        do_load(2'b11, 4'b0001);
        cmd_kind = 2'b10; cmd_ctrl = 4'h2; cmd_wb = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_busy0", 32'(busy), 32'd0);
        chk("mid_A", 32'(ALUA), 32'd0);
        chk("mid_F", 32'(ALUFlagIn), 32'd0);
        chk("mid_count", 32'(exec_count), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        chk("mid_A_after", 32'(ALUA), 32'd0);

        // Undefined opcode passes through
        do_load(2'b00, 4'b0111);
        do_exec(4'hC, 1'b0, 0);
        chk("inv_result", 32'(rsp_result), 32'd0);
        chk("inv_flags", 32'(rsp_flags), 32'b10);

        // Random traffic up to 256 EXECs since reset, then counter wrap
        execs = 1;
        while (execs < 256) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0:       do_load(2'b00, N'($urandom));
                    1:       do_load(2'b01, N'($urandom));
                    default: do_load(2'b11, N'($urandom));
                endcase
            end else begin
                do_exec(4'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 2)));
                execs++;
            end
        end
        chk("wrap_count", 32'(exec_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller that sits in front of `ALU_parametrizable` and drives its operand, control and flag-in ports. It accepts load, flag-set and execute commands over a valid/ready stream, and holds an accumulator (A), an operand register (B) and a carry flag (F). It issues each execute to the combinational ALU, captures `ALUResult`/`ALUFlags`, and returns them on a valid/ready response stream. It optionally writes the result back into A for chained operations.

## Interface

Parameters:
- `n`, default 4: ALU data width; must match the ALU instance.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_kind`  in  2  command type: 00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 SETF.
- `cmd_ctrl`  in  4  ALU operation code for EXEC (0x0–0x9 defined; other codes are passed through).
- `cmd_wb`  in  1  EXEC only: write the result back into A.
- `cmd_data`  in  n  operand for LOAD_A/LOAD_B; bit 0 is the new F for SETF.
- `ALUA`  out  n  registered A, to the ALU.
- `ALUB`  out  n  registered B, to the ALU.
- `ALUFlagIn`  out  1  registered F, to the ALU.
- `ALUControl`  out  4  registered operation code, to the ALU.
- `ALUResult`  in  n  ALU result (combinational from the ALU outputs above).
- `ALUFlags`  in  2  ALU flags: [1] zero, [0] shift carry.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  n  captured result.
- `rsp_flags`  out  2  captured flags.
- `busy`  out  1  high whenever the state is not IDLE.
- `exec_count`  out  8  number of completed EXEC responses; wraps 255→0.

## Operation

- Reset (async, `rst_n`=0) forces:
  - state IDLE; A, B, F, `ALUControl`, `rsp_result`, `rsp_flags`, `exec_count` all 0.
  - `rsp_valid`=0, `busy`=0, `cmd_ready`=1.
- States:
  - IDLE: `cmd_ready`=1.
  - DRIVE: ALU inputs stable for one full cycle.
  - RESP: `rsp_valid`=1.
- `cmd_ready` = (state == IDLE). A command is accepted on a cycle where `cmd_valid` and `cmd_ready` are both high.
- LOAD_A / LOAD_B: A or B ← `cmd_data` at the accepting edge. State stays IDLE. No response is generated.
- SETF: F ← `cmd_data[0]`. State stays IDLE. No response.
- EXEC, accepting edge: `ALUControl` ← `cmd_ctrl`; the `cmd_wb` value is latched internally; IDLE→DRIVE.
- DRIVE, next edge:
  - `rsp_result` ← `ALUResult`; `rsp_flags` ← `ALUFlags`.
  - F ← `ALUFlags[0]`.
  - If the latched `cmd_wb`=1: A ← `ALUResult`.
  - DRIVE→RESP.
- RESP: outputs hold until `rsp_valid`&&`rsp_ready`. On that edge: `exec_count` increments; RESP→IDLE.
- The ALU flags are not re-derived. A zero result gives flags[1]=1. flags[0] is non-zero only for codes 8/9. Codes ≥ 0xA return result 0, flags 10; the sequencer forwards these unchanged.
- Commands presented while `cmd_ready`=0 are neither consumed nor do they alter any register.
- A, B, F and `ALUControl` keep their values between commands. Consecutive EXECs therefore reuse the operands, and F carries over (carry chaining for shifts).

## Timing

- LOAD/SETF: the register is visible on the ALU ports one cycle after acceptance (edge T → valid from T).
- EXEC:
  - Accepted at edge T. `ALUControl` is new from T. The result is captured at edge T+1.
  - `rsp_valid` rises after T+1: 2-cycle latency from acceptance to the response.
- Write-back: the new A drives `ALUA` from T+1, so the next EXEC sees it.
- `cmd_ready` falls immediately after the EXEC acceptance edge. It returns high in the cycle after the response handshake edge.
- Peak throughput is 1 EXEC per 3 cycles with `rsp_ready` held high.
- Backpressure: while `rsp_ready`=0, `rsp_valid`, `rsp_result` and `rsp_flags` are held stable. No new command is accepted.
- Reset mid-operation (DRIVE or RESP) aborts immediately:
  - `rsp_valid`=0 asynchronously.
  - No write-back occurs.
  - `exec_count` is not incremented.

## Test plan

- Add: LOAD_A 0101, LOAD_B 0011, SETF 0, EXEC ctrl=2 → `rsp_valid` exactly 2 cycles after acceptance, `rsp_result`=1000, `rsp_flags`=00, `exec_count`=1.
- Shift carry-in: A=0011, B=0001, SETF 1, EXEC ctrl=8 → `ALUFlagIn`=1 during DRIVE, `rsp_result`=0111, `rsp_flags`=00, F=0 afterwards.
- Write-back chain:
  - A=1111, F=0, EXEC ctrl=3 with wb=1 → result 0000, flags 10, `ALUA`=0000.
  - Then B=0000, EXEC ctrl=1 → result 0000, flags 10.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with `cmd_valid`=1 (LOAD_A 1010) → response stable, `cmd_ready`=0, A unchanged. After the handshake, LOAD_A is accepted on the next cycle.
- Reset mid-EXEC: assert `rst_n`=0 in DRIVE → `rsp_valid`, `busy`, A, F and `exec_count` go to 0 at once. After release, `cmd_ready`=1.
- Invalid op: EXEC ctrl=0xC → `rsp_result`=0000, `rsp_flags`=10. `exec_count` still increments; `exec_count` wraps to 0 after 256 EXECs.
